// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file parameters and types, also used by the register file and decode.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int AW         = 5;
  localparam int NREG       = 1 << AW;
  localparam int STARVE_MAX = 4;
  localparam int STARVE_W   = 3;

  typedef logic [AW-1:0]   reg_idx_t;
  typedef logic [XLEN-1:0] xdata_t;

  typedef struct packed {
    logic     we;
    reg_idx_t rd;
    xdata_t   wdata;
  } rf_wr_t;

  // x0 never matches: it is hardwired and never pending.
  function automatic logic rs_match(reg_idx_t rs, reg_idx_t rd);
    return (rs != '0) && (rs == rd);
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ALU and LSU write-back request streams into the arbiter.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic     alu_valid;
  logic     alu_ready;
  reg_idx_t alu_rd;
  xdata_t   alu_wdata;
  logic     lsu_valid;
  logic     lsu_ready;
  reg_idx_t lsu_rd;
  xdata_t   lsu_wdata;

  modport master (
    output alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata,
    input  alu_ready, lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wdata, lsu_valid, lsu_rd, lsu_wdata,
    output alu_ready, lsu_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Load scoreboard: one busy bit per register plus the busy-based operand hazard.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_valid,
  input  reg_idx_t        set_rd,
  input  logic            clr_valid,
  input  reg_idx_t        clr_rd,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic [NREG-1:0] busy_vec,
  output logic            busy_hazard
);
  logic [NREG-1:0] busy, busy_nxt;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      if (clr_valid && clr_rd == reg_idx_t'(r)) busy_nxt[r] = 1'b0;
      if (set_valid && set_rd == reg_idx_t'(r)) busy_nxt[r] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign busy_vec    = busy;
  assign busy_hazard = (rs1 != '0 && busy[rs1]) || (rs2 != '0 && busy[rs2]);

  a_load_to_busy_rd: assert property (@(posedge clk) disable iff (!rst_n)
    !(set_valid && set_rd != '0 && busy[set_rd]));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port (LSU priority, ALU anti-starvation).
// Optional REGFILE_WB_BYPASS_EN adds operand forwarding from the pending write.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  regfile_wb_arbiter_if.slave wb,
  input  logic            iss_load_valid,
  input  reg_idx_t        iss_load_rd,
  input  reg_idx_t        rs1,
  input  reg_idx_t        rs2,
  output logic            hazard,
  output logic [NREG-1:0] busy_vec,
  output logic            rf_we,
  output reg_idx_t        rf_rd,
  output xdata_t          rf_wdata
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic            fwd1_valid,
  output logic            fwd2_valid,
  output xdata_t          fwd1_data,
  output xdata_t          fwd2_data
`endif
);
  logic [STARVE_W-1:0] starve_cnt;
  logic                starved, alu_gnt, lsu_gnt, busy_hazard;
  rf_wr_t              wr_q, wr_sel;

  // Grants are masked during reset so requesters must re-present afterwards.
  assign starved      = (starve_cnt == STARVE_W'(STARVE_MAX));
  assign alu_gnt      = rst_n && wb.alu_valid && (!wb.lsu_valid || starved);
  assign lsu_gnt      = rst_n && wb.lsu_valid && !(wb.alu_valid && starved);
  assign wb.alu_ready = alu_gnt;
  assign wb.lsu_ready = lsu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        starve_cnt <= '0;
    else if (!wb.alu_valid || alu_gnt) starve_cnt <= '0;
    else if (!starved)                 starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    wr_sel = wr_q;
    wr_sel.we = 1'b0;
    if (lsu_gnt)      wr_sel = '{we: wb.lsu_rd != '0, rd: wb.lsu_rd, wdata: wb.lsu_wdata};
    else if (alu_gnt) wr_sel = '{we: wb.alu_rd != '0, rd: wb.alu_rd, wdata: wb.alu_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_q <= '0;
    else        wr_q <= wr_sel;
  end

  assign rf_we    = wr_q.we;
  assign rf_rd    = wr_q.rd;
  assign rf_wdata = wr_q.wdata;

  wb_scoreboard u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_valid  (iss_load_valid),
    .set_rd     (iss_load_rd),
    .clr_valid  (lsu_gnt),
    .clr_rd     (wb.lsu_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .busy_vec   (busy_vec),
    .busy_hazard(busy_hazard)
  );

`ifdef REGFILE_WB_BYPASS_EN
  assign fwd1_valid = rf_we && rs_match(rs1, rf_rd);
  assign fwd2_valid = rf_we && rs_match(rs2, rf_rd);
  assign fwd1_data  = rf_wdata;
  assign fwd2_data  = rf_wdata;
  assign hazard     = busy_hazard;
`else
  // Without forwarding, an operand waits out the cycle its value sits in the write stage.
  assign hazard = busy_hazard ||
                  (rf_we && (rs_match(rs1, rf_rd) || rs_match(rs2, rf_rd)));
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed write-back, hazard and reset vectors.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct packed {
    reg_idx_t rd;
    xdata_t   d;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            iss_load_valid = 1'b0;
  reg_idx_t        iss_load_rd = '0;
  reg_idx_t        rs1 = '0, rs2 = '0;
  logic            hazard, rf_we;
  logic [NREG-1:0] busy_vec;
  reg_idx_t        rf_rd;
  xdata_t          rf_wdata;
`ifdef REGFILE_WB_BYPASS_EN
  logic            fwd1_valid, fwd2_valid;
  xdata_t          fwd1_data, fwd2_data;
`endif

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter_if wb();

  regfile_wb_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb            (wb),
    .iss_load_valid(iss_load_valid),
    .iss_load_rd   (iss_load_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .hazard        (hazard),
    .busy_vec      (busy_vec),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata)
`ifdef REGFILE_WB_BYPASS_EN
    ,
    .fwd1_valid    (fwd1_valid),
    .fwd2_valid    (fwd2_valid),
    .fwd1_data     (fwd1_data),
    .fwd2_data     (fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every register-file write the DUT presents must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual rd=%0d data=%0h expected none", rf_rd, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_rd", 64'(rf_rd), 64'(e.rd));
        chk("wr_data", 64'(rf_wdata), 64'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of write-back requests, check the grants, and queue the expected write.
  task automatic cycle_wb(input logic av, input reg_idx_t ard, input xdata_t ad,
                          input logic lv, input reg_idx_t lrd, input xdata_t ld,
                          input logic ea, input logic el, input bit track);
    wb.alu_valid = av; wb.alu_rd = ard; wb.alu_wdata = ad;
    wb.lsu_valid = lv; wb.lsu_rd = lrd; wb.lsu_wdata = ld;
    #1;
    chk("alu_ready", 64'(wb.alu_ready), 64'(ea));
    chk("lsu_ready", 64'(wb.lsu_ready), 64'(el));
    if (track) begin
      if (el && lrd != '0)      exp_q.push_back('{rd: lrd, d: ld});
      else if (ea && ard != '0) exp_q.push_back('{rd: ard, d: ad});
    end
  endtask

  task automatic idle();
    cycle_wb(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with both requesters asserted
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_wdata = 32'h11;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd6; wb.lsu_wdata = 32'h22;
    tick(); tick();
    chk("rst_alu_ready", 64'(wb.alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(wb.lsu_ready), 64'd0);
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("rst_busy", 64'(busy_vec), 64'd0);
    rst_n = 1'b1;

    // Contention: LSU x6 first, ALU x5 next
    cycle_wb(1'b1, 5'd5, 32'h11, 1'b1, 5'd6, 32'h22, 1'b0, 1'b1, 1'b1);
    tick();
    chk("lat_rf_we", 64'(rf_we), 64'd1);
    chk("lat_rf_rd", 64'(rf_rd), 64'd6);
    cycle_wb(1'b1, 5'd5, 32'h11, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    chk("idle_rf_we", 64'(rf_we), 64'd0);
    chk("hold_rf_rd", 64'(rf_rd), 64'd5);

    // Starvation: ALU wins on every 5th contended cycle
    for (int i = 0; i < 10; i++) begin
      cycle_wb(1'b1, 5'd3, 32'hA5 + 32'(i), 1'b1, reg_idx_t'(10 + i), 32'h100 + 32'(i),
               (i % 5) == 4, (i % 5) != 4, 1'b1);
      tick();
    end
    idle();
    tick();

    // Load scoreboard hazard on x7
    iss_load_valid = 1'b1; iss_load_rd = 5'd7;
    idle();
    tick();
    iss_load_valid = 1'b0; iss_load_rd = '0;
    rs1 = 5'd7;
    idle();
    chk("busy_x7", 64'(busy_vec), 64'h80);
    chk("haz_busy", 64'(hazard), 64'd1);
    tick();
    cycle_wb(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
    chk("haz_grant_cycle", 64'(hazard), 64'd1);
    tick();
    idle();
    chk("busy_clr_x7", 64'(busy_vec), 64'd0);
`ifdef REGFILE_WB_BYPASS_EN
    chk("haz_bypass", 64'(hazard), 64'd0);
    chk("fwd1_valid", 64'(fwd1_valid), 64'd1);
    chk("fwd1_data", 64'(fwd1_data), 64'hDEADBEEF);
    chk("fwd2_valid", 64'(fwd2_valid), 64'd0);
`else
    chk("haz_pending_wr", 64'(hazard), 64'd1);
`endif
    tick();
    idle();
    chk("haz_clear", 64'(hazard), 64'd0);
    rs1 = '0;
    tick();

    // Writes and loads to x0
    cycle_wb(1'b1, 5'd0, 32'hFFFF, 1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("x0_rf_we", 64'(rf_we), 64'd0);
    iss_load_valid = 1'b1; iss_load_rd = 5'd0;
    idle();
    tick();
    chk("x0_busy", 64'(busy_vec), 64'd0);

    // Same-cycle set and clear of x9: set wins
    iss_load_rd = 5'd9;
    cycle_wb(1'b0, '0, '0, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1);
    tick();
    iss_load_valid = 1'b0; iss_load_rd = '0;
    rs2 = 5'd9;
    idle();
    chk("busy_x9_kept", 64'(busy_vec), 64'h200);
    chk("haz_rs2_busy", 64'(hazard), 64'd1);
    tick();
    rs2 = '0;

    // Reset during a pending write drops it and clears the scoreboard
    cycle_wb(1'b0, '0, '0, 1'b1, 5'd12, 32'h1234, 1'b0, 1'b1, 1'b0);
    tick();
    chk("pre_rst_rf_we", 64'(rf_we), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rf_we", 64'(rf_we), 64'd0);
    chk("async_rst_busy", 64'(busy_vec), 64'd0);
    idle();
    tick();
    rst_n = 1'b1;
    idle();
    tick(); tick();
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
